// File: rtl/ledstring_rx.sv
// ---------------------------------------------------------------------------
// ledstring_rx : receive side of the LED-strip serial link.
//
// Oversamples the asynchronous sck/mosi pair with ledrx_clk, rebuilds the
// 32-bit words the LED driver emits (MSB first) and decodes them into
// start frames, per-LED colour words and end frames.
//
// Ports
//   ledrx_clk       in   system clock
//   ledrx_reset     in   synchronous active-low reset
//   sck_in          in   serial clock from the strip link (asynchronous)
//   mosi_in         in   serial data, captured on sck rising edges
//   led_valid       out  1-cycle pulse, led_* hold a new LED word
//   led_index       out  0-based LED position in the current frame
//   led_brightness  out  5-bit global brightness field
//   led_blue/green/red out colour bytes
//   frame_start     out  pulse when a 32-zero start frame completes
//   frame_done      out  pulse when an all-ones end frame completes
//   frame_error     out  pulse on a protocol violation or timeout
//   range_error     out  pulse with led_valid when a colour exceeds
//                        MAX_COLOR_VALUE (only with the optional feature)
//
// Optional feature macro: LEDSTRING_RX_RANGE_CHECK_EN
//   defined   : colour range comparator drives range_error
//   undefined : range_error is tied low, no comparator is built
// ---------------------------------------------------------------------------
module ledstring_rx #(
  parameter int STRING_SIZE     = 47,
  parameter int MAX_COLOR_VALUE = 100,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic       ledrx_clk,
  input  logic       ledrx_reset,
  input  logic       sck_in,
  input  logic       mosi_in,
  output logic       led_valid,
  output logic [7:0] led_index,
  output logic [4:0] led_brightness,
  output logic [7:0] led_blue,
  output logic [7:0] led_green,
  output logic [7:0] led_red,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_error,
  output logic       range_error
);

  // Elaboration-time sanity check of the configuration.
  if (SYNC_STAGES < 2 || STRING_SIZE < 1 || STRING_SIZE > 255 ||
      MAX_COLOR_VALUE < 0 || MAX_COLOR_VALUE > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ledstring_rx: illegal parameter combination");
  end

  localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   TO_MAX      = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]      STRING_SZ_W = 8'(STRING_SIZE);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_LED  = 2'd1,
    ST_END  = 2'd2
  } state_e;

  // Synchroniser chains; the highest index is the last (stable) stage.
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;

  state_e        state_q;
  logic [4:0]    bit_cnt_q;
  logic [5:0]    zero_cnt_q;
  logic [30:0]   shift_q;
  logic [TW-1:0] timeout_q;
  logic [7:0]    led_cnt_q;

  logic       led_valid_q;
  logic [7:0] led_index_q;
  logic [4:0] led_brightness_q;
  logic [7:0] led_blue_q;
  logic [7:0] led_green_q;
  logic [7:0] led_red_q;
  logic       frame_start_q;
  logic       frame_done_q;
  logic       frame_error_q;

  logic        sck_s;
  logic        mosi_s;
  logic        edge_s;
  logic [31:0] word_s;
  logic        word_done_s;
  logic        partial_s;
  logic        timeout_fire_s;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign edge_s = sck_s & ~sck_prev_q;

  // Word as it stands once the current bit is shifted in.
  assign word_s      = {shift_q, mosi_s};
  assign word_done_s = edge_s && (bit_cnt_q == 5'd31);

  // HUNT only resynchronises (and never flags) when a zero run is in progress.
  assign partial_s      = (state_q != ST_HUNT) || (zero_cnt_q != 6'd0) || (bit_cnt_q != 5'd0);
  // Timeout can only fire on a cycle without an edge, so a completing word
  // always wins over a simultaneous timeout.
  assign timeout_fire_s = !edge_s && (timeout_q == TO_LAST) && partial_s;

  // Synchronisers, decoder FSM, timeout and registered outputs.
  always_ff @(posedge ledrx_clk) begin
    if (!ledrx_reset) begin
      sck_sync_q       <= '0;
      mosi_sync_q      <= '0;
      sck_prev_q       <= 1'b0;
      state_q          <= ST_HUNT;
      bit_cnt_q        <= 5'd0;
      zero_cnt_q       <= 6'd0;
      shift_q          <= 31'd0;
      timeout_q        <= '0;
      led_cnt_q        <= 8'd0;
      led_valid_q      <= 1'b0;
      led_index_q      <= 8'd0;
      led_brightness_q <= 5'd0;
      led_blue_q       <= 8'd0;
      led_green_q      <= 8'd0;
      led_red_q        <= 8'd0;
      frame_start_q    <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_error_q    <= 1'b0;
    end else begin
      sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], sck_in};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sck_prev_q    <= sck_s;
      led_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;

      if (edge_s) begin
        timeout_q <= '0;
        shift_q   <= word_s[30:0];
        case (state_q)
          ST_HUNT: begin
            bit_cnt_q <= 5'd0;
            if (mosi_s) begin
              zero_cnt_q <= 6'd0;
            end else if (zero_cnt_q == 6'd31) begin
              zero_cnt_q    <= 6'd0;
              frame_start_q <= 1'b1;
              led_cnt_q     <= 8'd0;
              led_index_q   <= 8'd0;
              state_q       <= ST_LED;
            end else begin
              zero_cnt_q <= zero_cnt_q + 6'd1;
            end
          end

          ST_LED: begin
            // 5-bit counter wraps 31 -> 0 at the word boundary.
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (word_done_s) begin
              if (word_s[31:29] == 3'b111) begin
                led_valid_q      <= 1'b1;
                led_index_q      <= led_cnt_q;
                led_brightness_q <= word_s[28:24];
                led_blue_q       <= word_s[23:16];
                led_green_q      <= word_s[15:8];
                led_red_q        <= word_s[7:0];
                led_cnt_q        <= led_cnt_q + 8'd1;
                if ((led_cnt_q + 8'd1) == STRING_SZ_W) begin
                  state_q <= ST_END;
                end else begin
                  state_q <= ST_LED;
                end
              end else if ((word_s == 32'h0000_0000) && (led_cnt_q == 8'd0)) begin
                // Longer start frame: another zero word before LED 0.
                state_q <= ST_LED;
              end else begin
                frame_error_q <= 1'b1;
                state_q       <= ST_HUNT;
              end
            end
          end

          ST_END: begin
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (word_done_s) begin
              if (word_s == 32'hFFFF_FFFF) begin
                frame_done_q <= 1'b1;
              end else begin
                frame_error_q <= 1'b1;
              end
              state_q <= ST_HUNT;
            end
          end

          default: begin
            state_q   <= ST_HUNT;
            bit_cnt_q <= 5'd0;
          end
        endcase
      end else if (timeout_fire_s) begin
        // Link went quiet mid-frame: resynchronise. The counter parks at
        // its saturation value so HUNT does not fire again.
        frame_error_q <= (state_q != ST_HUNT);
        state_q       <= ST_HUNT;
        bit_cnt_q     <= 5'd0;
        zero_cnt_q    <= 6'd0;
        timeout_q     <= TO_MAX;
      end else if (timeout_q != TO_MAX) begin
        timeout_q <= timeout_q + TW'(1);
      end else begin
        timeout_q <= TO_MAX;
      end
    end
  end

`ifdef LEDSTRING_RX_RANGE_CHECK_EN
  localparam logic [7:0] MAX_COLOR = 8'(MAX_COLOR_VALUE);

  logic range_error_q;
  logic led_word_s;

  assign led_word_s = word_done_s && (state_q == ST_LED) && (word_s[31:29] == 3'b111);

  // Range flag registered in step with led_valid.
  always_ff @(posedge ledrx_clk) begin
    if (!ledrx_reset) begin
      range_error_q <= 1'b0;
    end else begin
      range_error_q <= led_word_s && ((word_s[23:16] > MAX_COLOR) ||
                                      (word_s[15:8]  > MAX_COLOR) ||
                                      (word_s[7:0]   > MAX_COLOR));
    end
  end

  assign range_error = range_error_q;
`else
  assign range_error = 1'b0;
`endif

  assign led_valid      = led_valid_q;
  assign led_index      = led_index_q;
  assign led_brightness = led_brightness_q;
  assign led_blue       = led_blue_q;
  assign led_green      = led_green_q;
  assign led_red        = led_red_q;
  assign frame_start    = frame_start_q;
  assign frame_done     = frame_done_q;
  assign frame_error    = frame_error_q;

endmodule
